// File: rtl/fetch_read_collector.sv
// Captures latency-delayed BRAM read data behind the fetch address generator,
// tags tile boundaries and buffers words in a first-word-fall-through FIFO.
module fetch_read_collector #(
  parameter int DATA_WIDTH   = 256,
  parameter int FIFO_DEPTH   = 512,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        tiles_control,
  input  logic                        bram_en,
  input  logic                        fetch_done,
  input  logic [DATA_WIDTH-1:0]       bram_dout,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        tile_space_ok,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow_err,
  output logic                        len_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LEN_W = CW'(32);
  localparam logic [CW-1:0] LEN_I = CW'(512);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                  state;
  logic [CW-1:0]           beat_count;
  logic [CW-1:0]           tile_len;
  logic [READ_LATENCY-1:0] en_pipe;
  logic                    cap_valid;
  logic                    done_d;
  logic                    tag_last;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    full;
  logic                    do_push;
  logic                    do_pop;
  logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]     head;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           pending;
  logic [CW+1:0]           demand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe <= '0;
    end else if (flush) begin
      en_pipe <= '0;
    end else begin
      en_pipe[0] <= bram_en;
      for (int i = 1; i < READ_LATENCY; i++) en_pipe[i] <= en_pipe[i-1];
    end
  end

  assign cap_valid = en_pipe[READ_LATENCY-1];

  // fetch_done needs one cycle less delay than bram_en to line up with the last capture
  generate
    if (READ_LATENCY == 1) begin : g_done_direct
      assign done_d = fetch_done;
    end else begin : g_done_pipe
      logic [READ_LATENCY-2:0] done_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          done_pipe <= '0;
        end else if (flush) begin
          done_pipe <= '0;
        end else begin
          done_pipe[0] <= fetch_done;
          for (int i = 1; i < READ_LATENCY - 1; i++) done_pipe[i] <= done_pipe[i-1];
        end
      end
      assign done_d = done_pipe[READ_LATENCY-2];
    end
  endgenerate

  assign tag_last = cap_valid && (state == COLLECT) && (beat_count == tile_len - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_count <= '0;
      tile_len   <= '0;
    end else if (flush) begin
      state      <= IDLE;
      beat_count <= '0;
      tile_len   <= '0;
    end else if (cap_valid) begin
      case (state)
        IDLE: begin
          tile_len   <= tiles_control ? LEN_W : LEN_I;
          beat_count <= CW'(1);
          state      <= COLLECT;
        end
        COLLECT: begin
          if (tag_last) begin
            beat_count <= '0;
            state      <= IDLE;
          end else begin
            beat_count <= beat_count + CW'(1);
          end
        end
        default: begin
          beat_count <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = (fill_level != '0);
  assign full      = (fill_level == CW'(FIFO_DEPTH));
  assign do_pop    = out_valid && out_ready && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push   = cap_valid && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {tag_last, bram_dout};
  end

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_last = out_valid && head[DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      overflow_err <= 1'b0;
      len_err      <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      overflow_err <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill_level <= fill_level + CW'(1);
        2'b01:   fill_level <= fill_level - CW'(1);
        default: fill_level <= fill_level;
      endcase
      overflow_err <= overflow_err | (cap_valid && full && !do_pop);
      len_err      <= len_err | (done_d ^ tag_last);
    end
  end

  // Words still owed to the FIFO: rest of the open tile, or reads in flight
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(en_pipe[i]);
    pending = (state == COLLECT) ? (tile_len - beat_count) : inflight;
    demand  = {2'b00, fill_level} + {2'b00, pending} +
              {2'b00, (tiles_control ? LEN_W : LEN_I)};
    tile_space_ok = (demand <= (CW+2)'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_fetch_read_collector.sv
// Bench for fetch_read_collector: two instances (read latency 1 and 3) share
// one randomized stimulus and are checked every cycle against a queue model.
module tb_fetch_read_collector;

  localparam int DW    = 256;
  localparam int DEPTH = 512;
  localparam int NLOG  = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, tiles_control, bram_en, fetch_done, out_ready;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] od [2];
  logic          ol [2], ov [2], tso [2], oe [2], le [2];
  logic [$clog2(DEPTH):0] fl [2];

  fetch_read_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .flush(flush), .tiles_control(tiles_control),
    .bram_en(bram_en), .fetch_done(fetch_done), .bram_dout(bram_dout),
    .out_data(od[0]), .out_last(ol[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .tile_space_ok(tso[0]), .fill_level(fl[0]), .overflow_err(oe[0]), .len_err(le[0]));

  fetch_read_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .flush(flush), .tiles_control(tiles_control),
    .bram_en(bram_en), .fetch_done(fetch_done), .bram_dout(bram_dout),
    .out_data(od[1]), .out_last(ol[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .tile_space_ok(tso[1]), .fill_level(fl[1]), .overflow_err(oe[1]), .len_err(le[1]));

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } ent_t;

  ent_t mq [2][$];
  int   mbeat [2];
  int   mlen  [2];
  bit   movf  [2];
  bit   mlerr [2];
  bit   en_log   [NLOG];
  bit   done_log [NLOG];
  int   ncyc, last_clear, n_cmp, n_fail, rdy_mode;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mbeat[i] = 0;
      mlen[i]  = 0;
      movf[i]  = 1'b0;
      mlerr[i] = 1'b0;
    end
    last_clear = ncyc;
  endtask

  // One clock edge of the reference: words appear L edges after their read enable
  task automatic model_edge();
    int k, kd;
    bit cap, dd, tag, pop;
    ncyc++;
    en_log[ncyc]   = bram_en;
    done_log[ncyc] = fetch_done;
    if (rst || flush) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        k   = ncyc - lat(i);
        kd  = ncyc - lat(i) + 1;
        cap = (k > last_clear) && en_log[k];
        dd  = (kd > last_clear) && done_log[kd];
        tag = 1'b0;
        if (cap) begin
          if (mbeat[i] == 0) begin
            mlen[i]  = tiles_control ? 32 : 512;
            mbeat[i] = 1;
          end else if (mbeat[i] == mlen[i] - 1) begin
            tag      = 1'b1;
            mbeat[i] = 0;
          end else begin
            mbeat[i]++;
          end
        end
        pop = (mq[i].size() > 0) && out_ready;
        if (pop) void'(mq[i].pop_front());
        if (cap) begin
          if (mq[i].size() < DEPTH) mq[i].push_back('{d: bram_dout, l: tag});
          else movf[i] = 1'b1;
        end
        if (dd != tag) mlerr[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int inflight, pend, fill;
    bit exp_ok;
    logic [DW-1:0] exp_d;
    logic exp_l;
    for (int i = 0; i < 2; i++) begin
      inflight = 0;
      for (int k = ncyc - lat(i) + 1; k <= ncyc; k++)
        if (k > last_clear && en_log[k]) inflight++;
      fill   = mq[i].size();
      pend   = (mbeat[i] != 0) ? (mlen[i] - mbeat[i]) : inflight;
      exp_ok = (DEPTH - fill - pend) >= (tiles_control ? 32 : 512);
      exp_d  = (fill > 0) ? mq[i][0].d : '0;
      exp_l  = (fill > 0) ? mq[i][0].l : 1'b0;
      chk("out_valid",     i, DW'(ov[i]),  DW'(fill > 0));
      chk("out_data",      i, od[i],       exp_d);
      chk("out_last",      i, DW'(ol[i]),  DW'(exp_l));
      chk("fill_level",    i, DW'(fl[i]),  DW'(fill));
      chk("tile_space_ok", i, DW'(tso[i]), DW'(exp_ok));
      chk("overflow_err",  i, DW'(oe[i]),  DW'(movf[i]));
      chk("len_err",       i, DW'(le[i]),  DW'(mlerr[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    bram_dout = rnd_word();
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic set_mode(input int m);
    rdy_mode  = m;
    out_ready = (m == 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tile(input logic tc, input int n, input bit send_done);
    tiles_control = tc;
    for (int b = 0; b < n; b++) begin
      bram_en = 1'b1;
      step();
    end
    bram_en    = 1'b0;
    fetch_done = send_done;
    step();
    fetch_done = 1'b0;
    idle(4);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    idle(2);
    rst = 1'b0;
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; tiles_control = 1'b0; bram_en = 1'b0;
    fetch_done = 1'b0; out_ready = 1'b0; rdy_mode = 0;
    bram_dout = rnd_word();
    ncyc = 0; last_clear = 0; n_cmp = 0; n_fail = 0;
    model_clear();
    idle(3);
    rst = 1'b0;
    step();

    // weight tile streamed straight through
    set_mode(1);
    tile(1'b1, 32, 1'b1);
    idle(4);
    for (int i = 0; i < 2; i++) begin
      chk("t1_fill_zero", i, DW'(fl[i]), DW'(0));
      chk("t1_len_ok",    i, DW'(le[i]), DW'(0));
    end

    // input tile under full backpressure, then drain
    set_mode(0);
    tile(1'b0, 512, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("t2_full",     i, DW'(fl[i]),  DW'(512));
      chk("t2_no_space", i, DW'(tso[i]), DW'(0));
      chk("t2_no_ovf",   i, DW'(oe[i]),  DW'(0));
    end
    set_mode(1);
    idle(520);
    for (int i = 0; i < 2; i++) begin
      chk("t2_drained", i, DW'(fl[i]),  DW'(0));
      chk("t2_space",   i, DW'(tso[i]), DW'(1));
    end

    // overflow: 500 held, 32-beat tile leaves 12 stored
    set_mode(0);
    tile(1'b0, 512, 1'b1);
    set_mode(1);
    idle(12);
    set_mode(0);
    idle(1);
    for (int i = 0; i < 2; i++) chk("t3_500", i, DW'(fl[i]), DW'(500));
    tile(1'b1, 32, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("t3_full", i, DW'(fl[i]), DW'(512));
      chk("t3_ovf",  i, DW'(oe[i]), DW'(1));
    end

    // full FIFO with simultaneous push and pop
    do_flush();
    tile(1'b0, 512, 1'b1);
    set_mode(1);
    tile(1'b1, 32, 1'b1);
    for (int i = 0; i < 2; i++) chk("t4_no_ovf", i, DW'(oe[i]), DW'(0));
    idle(560);

    // short tile -> length error, cleared by flush
    tile(1'b1, 31, 1'b1);
    for (int i = 0; i < 2; i++) chk("t5_len_err", i, DW'(le[i]), DW'(1));
    do_flush();
    for (int i = 0; i < 2; i++) begin
      chk("t5_flush_len", i, DW'(le[i]),  DW'(0));
      chk("t5_flush_vld", i, DW'(ov[i]),  DW'(0));
      chk("t5_flush_ok",  i, DW'(tso[i]), DW'(1));
    end

    // random ready, then async reset in the middle of a tile
    set_mode(2);
    tile(1'b1, 32, 1'b1);
    idle(40);
    tiles_control = 1'b1;
    for (int b = 0; b < 10; b++) begin
      bram_en = 1'b1;
      step();
    end
    bram_en = 1'b0;
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      chk("t6_rst_fill", i, DW'(fl[i]),  DW'(0));
      chk("t6_rst_ok",   i, DW'(tso[i]), DW'(1));
    end

    // randomized tile mix with occasional short tiles and gaps
    for (int t = 0; t < 10; t++) begin
      n = ($urandom_range(0, 2) != 0) ? 32 : 512;
      if ($urandom_range(0, 7) == 0) n = n - 1;
      tile((n < 100) ? 1'b1 : 1'b0, n, 1'($urandom_range(0, 7) != 0));
      idle($urandom_range(0, 3));
    end
    set_mode(1);
    idle(DEPTH + 20);
    for (int i = 0; i < 2; i++) chk("final_empty", i, DW'(ov[i]), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_read_collector.md
Name: fetch_read_collector

Overview:
- Sits directly downstream of the arbiter's BRAM fetch address generator.
- Captures BRAM read data returned for each bram_en beat, accounting for the fixed BRAM read latency.
- Tags tile boundaries (32-beat weight tiles / 512-beat input tiles) and buffers words in a FWFT FIFO.
- Streams to the compute datapath over valid/ready and gives the arbiter a space-available flag for gating start_fetch.

Parameters:
- DATA_WIDTH, 256, BRAM word / stream width in bits.
- FIFO_DEPTH, 512, buffered words; power of two, must be >= 512.
- READ_LATENCY, 1, cycles from bram_en to valid bram_dout; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO, pipelines, counters and error flags.
- tiles_control  in  1  1 = 32-beat tiles (weights), 0 = 512-beat tiles (inputs); same meaning as the fetcher's Tiles_Control.
- bram_en  in  1  read-enable issued by the fetcher, one per requested word.
- fetch_done  in  1  fetcher end-of-tile pulse.
- bram_dout  in  DATA_WIDTH  BRAM read data.
- out_data  out  DATA_WIDTH  FIFO head word.
- out_last  out  1  head word is the last beat of its tile.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept.
- tile_space_ok  out  1  a full tile of length given by tiles_control can be fetched without overflow.
- fill_level  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- overflow_err  out  1  sticky: a captured word was dropped because the FIFO was full.
- len_err  out  1  sticky: tile length mismatched fetch_done timing.

Behaviour:
Reset and flush:
- Reset (async) and flush (sync) clear all of the following:
  - the en/done delay pipes and beat_count;
  - FIFO pointers and fill_level (out_valid=0, out_last=0, out_data=0);
  - overflow_err, len_err.
- After reset or flush, tile_space_ok=1.
- Flush has priority over every same-cycle event. A captured beat arriving in the flush cycle is discarded.

Capture:
- cap_valid = bram_en delayed READ_LATENCY cycles via a shift register.
- When cap_valid=1, bram_dout is sampled that cycle and pushed.
- Nothing is sampled when cap_valid=0.

Tile tracking FSM:
- IDLE (beat_count=0):
  - On cap_valid, latch tile_len = tiles_control ? 32 : 512.
  - Push the word with last=0 and go to COLLECT with beat_count=1.
  - If tile_len==1 is not reachable, no special case.
- COLLECT:
  - Each cap_valid increments beat_count.
  - The word with beat_count==tile_len-1 is pushed with last=1; beat_count returns to 0 and the FSM goes to IDLE.
- tiles_control changes are ignored until the next tile's first beat.

Length check:
- done_d = fetch_done delayed READ_LATENCY-1 cycles (zero delay when READ_LATENCY=1). done_d aligns with the last captured beat.
- Set len_err if either:
  - done_d=1 and the beat captured that cycle is not tagged last (including no capture); or
  - a last-tagged beat is captured with done_d=0.
- The data stream is unaffected; len_err holds until reset/flush.

FIFO:
- First-word-fall-through: out_data/out_last show the head whenever out_valid=1.
- Pop when out_valid & out_ready. Push when cap_valid.
- Push with full and a same-cycle pop: both occur and fill_level is unchanged.
- Push with full and no pop: the word is dropped, overflow_err is set, and the beat still counts toward beat_count.
- Pop when empty: ignored.
- fill_level = stored words, 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Space flag:
- tile_space_ok is combinational from registered state:
  - tile_space_ok = (FIFO_DEPTH - fill_level - pending) >= (tiles_control ? 32 : 512).
  - pending = tile_len - beat_count in COLLECT, else the count of en bits in flight in the delay pipe.
- The arbiter asserts start_fetch only when tile_space_ok=1.

Latency:
- bram_en to push: READ_LATENCY cycles.
- Push into an empty FIFO to out_valid: 1 cycle.

Test Plan:
1. Weight tile: tiles_control=1, 32 consecutive bram_en, fetch_done one cycle after the last, READ_LATENCY=1, out_ready=1, bram_dout=beat index -> out_data 0..31 in order, out_last only on 31, len_err=0, fill_level back to 0.
2. Input tile with backpressure: tiles_control=0, 512 beats, out_ready=0 -> fill_level=512, tile_space_ok=0, overflow_err=0. Then out_ready=1 -> 512 words drain with out_last on the 512th, and tile_space_ok returns to 1 once fill_level<=0 for 512-beat tiles.
3. Overflow: FIFO holding 500 words, out_ready=0, force a 32-beat tile -> 12 words stored (fill_level=512), overflow_err=1 sticky, out_last tag lost with the dropped word.
4. Full simultaneous push/pop: fill_level=512, out_ready=1 while capturing -> fill_level stays 512, no overflow_err, order preserved.
5. Length error: tiles_control=1, only 31 bram_en then fetch_done -> len_err=1. Flush -> len_err=0, fill_level=0, out_valid=0, tile_space_ok=1.
6. READ_LATENCY=3 plus mid-tile async rst: 32-beat tile -> first push 3 cycles after the first bram_en, last aligned with the delayed fetch_done. Assert rst at beat 10 -> all outputs 0 immediately, tile_space_ok=1 after release.
